ex_shift_var_pipe: RTL and testbench

//  Parametrised, pipelined variable-amount shift/rotate unit for the EX lane;

---
 rtl/ex_shift_var_pipe.sv | 222 ++++++++++++++++++++++
 tb/tb_ex_shift_var_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_shift_var_pipe.sv
// Pipelined variable-amount shift/rotate unit for the EX lane (WIDTH bits, STAGES latency).
// Funnel shifts FSHL/FSHR (ops A/B) are built only when JX2_SHIFT_FUNNEL_EN is defined.
module ex_shift_var_pipe #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exHold,
  input  logic             exFlush,
  input  logic             regInValid,
  input  logic [3:0]       regIdIxt,
  input  logic [WIDTH-1:0] regValRm,
  input  logic [7:0]       regValRn,
  input  logic [WIDTH-1:0] regValRo,
  input  logic             regInSrT,
  output logic             regOutValid,
  output logic [WIDTH-1:0] regOutVal,
  output logic             regOutSrT
);

  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned FINE_W = CNT_W / 2;
  localparam int unsigned VEC_W  = 2 * WIDTH + 1;

  // Every op is reduced to a right shift of {hi, lo, t}; left ops run on bit-reversed data.
  typedef struct packed {
    logic [VEC_W-1:0]  vec;
    logic [FINE_W-1:0] fine;
    logic              rev;
    logic              keep_t;
    logic              t_in;
  } stage_t;

  function automatic logic [WIDTH-1:0] f_rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] y;
    for (int i = 0; i < int'(WIDTH); i++) y[i] = x[int'(WIDTH) - 1 - i];
    return y;
  endfunction

  // Fine shift, un-reverse and T select; returns {result, T}.
  function automatic logic [WIDTH:0] f_fine(input stage_t s);
    logic [WIDTH:0]   w;
    logic [WIDTH-1:0] res;
    w   = (WIDTH+1)'(s.vec >> s.fine);
    res = s.rev ? f_rev(w[WIDTH:1]) : w[WIDTH:1];
    return {res, (s.keep_t ? s.t_in : w[0])};
  endfunction

  logic [WIDTH-1:0] w_rm_rev;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_dres;
  logic [7:0]       w_mag;
  logic [7:0]       w_amt;
  logic [CNT_W-1:0] w_n;
  logic             w_sign;
  logic             w_neg;
  logic             w_fill;
  logic             w_left;
  logic             w_is_shift;
  logic             w_rot;
  logic             w_keep;
  logic             w_direct;
  logic             w_dt;
  logic             w_sat;
  logic             w_tsat;
  logic [VEC_W-1:0] w_vec;
  stage_t           w_s1;
`ifdef JX2_SHIFT_FUNNEL_EN
  logic             w_fun;
`else
  logic             w_unused_ro;
  assign w_unused_ro = ^regValRo;
`endif

  // Decode, saturation and coarse shift (amount bits above FINE_W).
  always_comb begin
    w_s1       = '0;
    w_rm_rev   = f_rev(regValRm);
    w_sign     = regValRm[WIDTH-1];
    w_neg      = regValRn[7];
    w_mag      = w_neg ? 8'(-regValRn) : regValRn;
    w_amt      = regValRn;
    w_fill     = 1'b0;
    w_left     = 1'b0;
    w_is_shift = 1'b0;
    w_rot      = 1'b0;
    w_keep     = 1'b0;
    w_direct   = 1'b0;
    w_dres     = '0;
    w_dt       = regInSrT;
`ifdef JX2_SHIFT_FUNNEL_EN
    w_fun      = 1'b0;
`endif
    case (regIdIxt)
      4'h0: begin w_is_shift = 1'b1; w_left = 1'b1; end
      4'h1: w_is_shift = 1'b1;
      4'h2: begin w_is_shift = 1'b1; w_fill = w_sign; end
      4'h3: begin w_rot = 1'b1; w_left = 1'b1; w_keep = 1'b1; end
      4'h4: begin w_rot = 1'b1; w_keep = 1'b1; end
      4'h5: begin
        w_direct = 1'b1;
        w_dres   = {regValRm[WIDTH-2:0], regInSrT};
        w_dt     = regValRm[WIDTH-1];
      end
      4'h6: begin
        w_direct = 1'b1;
        w_dres   = {regInSrT, regValRm[WIDTH-1:1]};
        w_dt     = regValRm[0];
      end
      4'h7: begin
        w_is_shift = 1'b1;
        w_amt      = w_mag;
        w_left     = ~w_neg;
        w_fill     = w_neg & w_sign;
      end
      4'h8: begin
        w_is_shift = 1'b1;
        w_amt      = w_mag;
        w_left     = ~w_neg;
      end
`ifdef JX2_SHIFT_FUNNEL_EN
      4'hA: begin w_fun = 1'b1; w_left = 1'b1; w_keep = 1'b1; end
      4'hB: begin w_fun = 1'b1; w_keep = 1'b1; end
`endif
      default: w_direct = 1'b1;
    endcase

    w_lo = w_left ? w_rm_rev : regValRm;
    w_hi = w_rot ? w_lo : {WIDTH{w_fill}};
`ifdef JX2_SHIFT_FUNNEL_EN
    if (w_fun) w_hi = w_left ? f_rev(regValRo) : regValRo;
`endif
    w_n    = w_amt[CNT_W-1:0];
    w_sat  = w_is_shift && ({1'b0, w_amt} >= 9'(WIDTH));
    // Shifting by exactly WIDTH still reports the last real bit out.
    w_tsat = (w_amt == 8'(WIDTH)) ? w_lo[WIDTH-1] : w_fill;
    w_vec  = {w_hi, w_lo, regInSrT};

    if (w_direct) begin
      w_s1.vec = {{WIDTH{1'b0}}, w_dres, w_dt};
    end else if (w_sat) begin
      w_s1.vec = {{WIDTH{1'b0}}, {WIDTH{w_fill}}, w_tsat};
    end else begin
      w_s1.vec    = w_vec >> {w_n[CNT_W-1:FINE_W], {FINE_W{1'b0}}};
      w_s1.fine   = w_n[FINE_W-1:0];
      w_s1.rev    = w_left;
      w_s1.keep_t = w_keep;
      w_s1.t_in   = regInSrT;
    end
  end

  stage_t         w_fin_src;
  logic           w_fin_v;
  logic [WIDTH:0] w_fin;
  logic [WIDTH:0] w_out_d;
  logic           w_out_v;

  generate
    if (STAGES == 1) begin : g_s1_comb
      assign w_fin_src = w_s1;
      assign w_fin_v   = regInValid;
    end else begin : g_s1_reg
      stage_t r_s1;
      logic   r_s1_v;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_s1_v <= 1'b0;
          r_s1   <= '0;
        end else if (exFlush) begin
          r_s1_v <= 1'b0;
        end else if (!exHold) begin
          r_s1_v <= regInValid;
          if (regInValid) r_s1 <= w_s1;
        end
      end
      assign w_fin_src = r_s1;
      assign w_fin_v   = r_s1_v;
    end
  endgenerate

  assign w_fin = f_fine(w_fin_src);

  generate
    if (STAGES == 3) begin : g_s2_reg
      logic [WIDTH:0] r_s2;
      logic           r_s2_v;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_s2_v <= 1'b0;
          r_s2   <= '0;
        end else if (exFlush) begin
          r_s2_v <= 1'b0;
        end else if (!exHold) begin
          r_s2_v <= w_fin_v;
          if (w_fin_v) r_s2 <= w_fin;
        end
      end
      assign w_out_d = r_s2;
      assign w_out_v = r_s2_v;
    end else begin : g_s2_bypass
      assign w_out_d = w_fin;
      assign w_out_v = w_fin_v;
    end
  endgenerate

  // Output stage; data keeps the last valid result between ops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regOutValid <= 1'b0;
      regOutVal   <= '0;
      regOutSrT   <= 1'b0;
    end else if (exFlush) begin
      regOutValid <= 1'b0;
    end else if (!exHold) begin
      regOutValid <= w_out_v;
      if (w_out_v) {regOutVal, regOutSrT} <= w_out_d;
    end
  end

endmodule

// File: tb/tb_ex_shift_var_pipe.sv
// Directed bench for ex_shift_var_pipe at WIDTH=64, STAGES=2.
// Funnel expectations follow JX2_SHIFT_FUNNEL_EN.
module tb_ex_shift_var_pipe;
  localparam int unsigned WIDTH = 64;
  localparam int NV = 20;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] rm;
    logic [7:0]  rn;
    logic [63:0] ro;
    logic        t;
    logic [63:0] ev;
    logic        et;
  } vec_t;

`ifdef JX2_SHIFT_FUNNEL_EN
  localparam logic [63:0] FSHL_EXP = 64'h3;
  localparam logic [63:0] FSHR_EXP = 64'h1000_0000_0000_0000;
`else
  localparam logic [63:0] FSHL_EXP = 64'h0;
  localparam logic [63:0] FSHR_EXP = 64'h0;
`endif

  logic        clock;
  logic        reset;
  logic        exHold;
  logic        exFlush;
  logic        regInValid;
  logic [3:0]  regIdIxt;
  logic [63:0] regValRm;
  logic [7:0]  regValRn;
  logic [63:0] regValRo;
  logic        regInSrT;
  logic        regOutValid;
  logic [63:0] regOutVal;
  logic        regOutSrT;

  int   checks;
  int   errors;
  vec_t vecs [NV];

  ex_shift_var_pipe #(.WIDTH(WIDTH), .STAGES(2)) dut (
    .clock(clock), .reset(reset), .exHold(exHold), .exFlush(exFlush),
    .regInValid(regInValid), .regIdIxt(regIdIxt), .regValRm(regValRm),
    .regValRn(regValRn), .regValRo(regValRo), .regInSrT(regInSrT),
    .regOutValid(regOutValid), .regOutVal(regOutVal), .regOutSrT(regOutSrT)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input vec_t v);
    regIdIxt = v.op;
    regValRm = v.rm;
    regValRn = v.rn;
    regValRo = v.ro;
    regInSrT = v.t;
  endtask

  task automatic drive_shl(input logic [63:0] rm, input logic [7:0] rn);
    regIdIxt = 4'h0;
    regValRm = rm;
    regValRn = rn;
    regValRo = '0;
    regInSrT = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [63:0] val, input logic t);
    chk({name, " valid"}, 64'(regOutValid), 64'(v));
    chk({name, " val"}, regOutVal, val);
    chk({name, " T"}, 64'(regOutSrT), 64'(t));
  endtask

  logic [63:0] hexp [4];
  int          n_got;
  logic        held;

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{4'h0, 64'h8000_0000_0000_0001, 8'd1,   64'h0, 1'b0, 64'h2, 1'b1};
    vecs[1]  = '{4'h2, 64'h8000_0000_0000_0000, 8'd70,  64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[2]  = '{4'h7, 64'h0000_0000_0000_0F00, 8'hFC,  64'h0, 1'b1, 64'hF0, 1'b0};
    vecs[3]  = '{4'h8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hC0,  64'h0, 1'b0, 64'h0, 1'b1};
    vecs[4]  = '{4'h6, 64'h1,                   8'd0,   64'h0, 1'b1, 64'h8000_0000_0000_0000, 1'b1};
    vecs[5]  = '{4'h3, 64'h8000_0000_0000_0000, 8'd65,  64'h0, 1'b1, 64'h1, 1'b1};
    vecs[6]  = '{4'h1, 64'h0123_4567_89AB_CDEF, 8'd4,   64'h0, 1'b0, 64'h0012_3456_789A_BCDE, 1'b1};
    vecs[7]  = '{4'h0, 64'h1,                   8'd0,   64'h0, 1'b1, 64'h1, 1'b1};
    vecs[8]  = '{4'h0, 64'h1,                   8'd64,  64'h0, 1'b0, 64'h0, 1'b1};
    vecs[9]  = '{4'h1, 64'h8000_0000_0000_0000, 8'd65,  64'h0, 1'b1, 64'h0, 1'b0};
    vecs[10] = '{4'h2, 64'h8000_0000_0000_0000, 8'd4,   64'h0, 1'b1, 64'hF800_0000_0000_0000, 1'b0};
    vecs[11] = '{4'h4, 64'h1,                   8'd4,   64'h0, 1'b0, 64'h1000_0000_0000_0000, 1'b0};
    vecs[12] = '{4'h5, 64'h8000_0000_0000_0001, 8'd0,   64'h0, 1'b0, 64'h2, 1'b1};
    vecs[13] = '{4'h7, 64'h8000_0000_0000_0000, 8'h80,  64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[14] = '{4'h8, 64'hF,                   8'd4,   64'h0, 1'b1, 64'hF0, 1'b0};
    vecs[15] = '{4'hC, 64'hFFFF_FFFF_FFFF_FFFF, 8'd3,   64'h0, 1'b1, 64'h0, 1'b1};
    vecs[16] = '{4'hA, 64'h1, 8'd1, 64'h8000_0000_0000_0000, 1'b1, FSHL_EXP, 1'b1};
    vecs[17] = '{4'hB, 64'h2, 8'd4, 64'h1,                   1'b0, FSHR_EXP, 1'b0};
    vecs[18] = '{4'h4, 64'hF,                   8'h40,  64'h0, 1'b1, 64'hF, 1'b1};
    vecs[19] = '{4'h1, 64'h8000_0000_0000_0000, 8'd64,  64'h0, 1'b0, 64'h0, 1'b1};
    hexp[0] = 64'h2; hexp[1] = 64'h4; hexp[2] = 64'h8; hexp[3] = 64'h10;

    reset = 1'b0; exHold = 1'b0; exFlush = 1'b0; regInValid = 1'b0;
    drive_shl(64'h0, 8'd0);
    #3;
    chk_out("reset", 1'b0, 64'h0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    step();

    // Back-to-back table, one result per clock two clocks after issue.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        drive(vecs[i]);
        regInValid = 1'b1;
      end else begin
        regInValid = 1'b0;
      end
      step();
      if (i >= 1) chk_out($sformatf("vec%0d", i - 1), 1'b1, vecs[i-1].ev, vecs[i-1].et);
    end
    step();
    chk("idle valid", 64'(regOutValid), 64'd0);

    // Hold for 3 clocks during a 4-op burst; the op offered while held is re-presented.
    n_got = 0;
    for (int c = 0; c < 12; c++) begin
      int idx;
      idx = (c < 2) ? c : ((c <= 5) ? 2 : 3);
      regInValid = (c <= 6);
      exHold     = (c >= 2 && c <= 4);
      drive_shl(64'h1, 8'(idx + 1));
      held = exHold;
      step();
      if (held) begin
        chk($sformatf("hold c%0d frozen valid", c), 64'(regOutValid), 64'd1);
        if (n_got > 0) chk($sformatf("hold c%0d frozen val", c), regOutVal, hexp[n_got-1]);
      end else if (regOutValid) begin
        if (n_got < 4) chk($sformatf("hold order %0d", n_got), regOutVal, hexp[n_got]);
        n_got++;
      end
    end
    exHold = 1'b0;
    regInValid = 1'b0;
    chk("hold count", 64'(n_got), 64'd4);

    // Flush while held drops everything still in flight.
    regIdIxt = 4'h1; regValRm = 64'hF0; regValRn = 8'd4; regInSrT = 1'b0;
    regInValid = 1'b1;
    step();
    regValRm = 64'hF00;
    step();
    chk_out("flush pre", 1'b1, 64'hF, 1'b0);
    regInValid = 1'b0;
    exHold = 1'b1;
    step();
    chk_out("flush held", 1'b1, 64'hF, 1'b0);
    exFlush = 1'b1;
    step();
    chk("flush valid", 64'(regOutValid), 64'd0);
    exHold = 1'b0;
    exFlush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("flush drain %0d", c), 64'(regOutValid), 64'd0);
    end

    // Asynchronous reset with two ops in flight, then latency of the first new op.
    drive_shl(64'h1, 8'd3);
    regInValid = 1'b1;
    step();
    drive_shl(64'h1, 8'd5);
    step();
    chk_out("rst pre", 1'b1, 64'h8, 1'b0);
    regInValid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_out("rst async", 1'b0, 64'h0, 1'b0);
    #2;
    reset = 1'b1;
    step();
    chk("rst stale", 64'(regOutValid), 64'd0);
    regIdIxt = 4'h4; regValRm = 64'h1; regValRn = 8'd1; regValRo = '0; regInSrT = 1'b1;
    regInValid = 1'b1;
    step();
    regInValid = 1'b0;
    chk("rst lat1 valid", 64'(regOutValid), 64'd0);
    step();
    chk_out("rst lat2", 1'b1, 64'h8000_0000_0000_0000, 1'b1);
    step();
    chk("rst single", 64'(regOutValid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
